// File: rtl/pkt_rx_pkg.sv
// Shared state encoding, SFD constant and byte helpers for the packet receiver.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package pkt_rx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PCK_SFD,
      PCK_TYPE,
      PCK_SIZE,
      PCK_PAYLOAD,
      PCK_FCS,
      PCK_WAIT
   } state_t;

   localparam logic [31:0] C_SFD = 32'h5555557F;

   // Running frame check: 8-bit wrap-around sum of size and payload bytes.
   function automatic logic [7:0] fcs_acc(input logic [7:0] acc, input logic [7:0] dat);
      return acc + dat;
   endfunction

   // SFD byte in wire order, byte 0 first.
   function automatic logic [7:0] sfd_byte(input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = C_SFD[31:24];
         2'd1:    b = C_SFD[23:16];
         2'd2:    b = C_SFD[15:8];
         default: b = C_SFD[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/pkt_rx_buffer.sv
// Circular 9-bit packet buffer with write/commit/rollback and fetch/read pointers.
// Latency: one cycle from i_fetch_en to o_rd_vld/o_rd_dat (registered read port).
// Backpressure: caller only fetches committed data it can absorb; i_pop frees space.
module pkt_rx_buffer #(
   parameter int G_MEM_SIZE = 512
) (
   input  logic                        clk_in,
   input  logic                        rst_n_in,
   input  logic                        i_wr_en,
   input  logic [8:0]                  i_wr_dat,
   input  logic                        i_commit,
   input  logic                        i_rollback,
   input  logic                        i_fetch_en,
   input  logic                        i_pop,
   output logic                        o_rd_vld,
   output logic [8:0]                  o_rd_dat,
   output logic [$clog2(G_MEM_SIZE):0] o_free,
   output logic [$clog2(G_MEM_SIZE):0] o_cmt_cnt
);
   import pkt_rx_pkg::*;

   localparam int            AW      = $clog2(G_MEM_SIZE);
   localparam logic [AW:0]   C_ONE   = (AW+1)'(1);
   localparam logic [AW:0]   C_DEPTH = (AW+1)'(G_MEM_SIZE);

   logic [8:0]  r_mem [G_MEM_SIZE];
   logic [AW:0] r_wr_ptr;     // next write slot, may run ahead of commit
   logic [AW:0] r_cmt_ptr;    // end of the last good packet
   logic [AW:0] r_fetch_ptr;  // next slot to read out of the RAM
   logic [AW:0] r_rd_ptr;     // next slot still owed to downstream
   logic        r_rd_vld;
   logic [8:0]  r_rd_dat;

   // Storage and registered read port; kept reset-free so it maps onto block RAM.
   always_ff @(posedge clk_in) begin
      if (i_wr_en) begin
         r_mem[r_wr_ptr[AW-1:0]] <= i_wr_dat;
      end
      if (i_fetch_en) begin
         r_rd_dat <= r_mem[r_fetch_ptr[AW-1:0]];
      end
   end

   // Pointer bookkeeping; rollback rewinds only the uncommitted tail.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_wr_ptr    <= '0;
         r_cmt_ptr   <= '0;
         r_fetch_ptr <= '0;
         r_rd_ptr    <= '0;
         r_rd_vld    <= 1'b0;
      end else begin
         if (i_rollback) begin
            r_wr_ptr <= r_cmt_ptr;
         end else if (i_wr_en) begin
            r_wr_ptr <= r_wr_ptr + C_ONE;
         end
         if (i_commit) begin
            r_cmt_ptr <= r_wr_ptr;
         end
         if (i_fetch_en) begin
            r_fetch_ptr <= r_fetch_ptr + C_ONE;
         end
         if (i_pop) begin
            r_rd_ptr <= r_rd_ptr + C_ONE;
         end
         r_rd_vld <= i_fetch_en;
      end
   end

   // Space is measured against bytes not yet handed downstream, so data parked
   // in the output registers still counts as occupied.
   assign o_free    = C_DEPTH - (r_wr_ptr - r_rd_ptr);
   assign o_cmt_cnt = r_cmt_ptr - r_fetch_ptr;
   assign o_rd_vld  = r_rd_vld;
   assign o_rd_dat  = r_rd_dat;

endmodule

// File: rtl/pkt_rx_sf.sv
// Store-and-forward receiver: parses/checks framed bytes, buffers good payloads, replays them.
// Latency: first output byte valid 2 cycles after the FCS byte edge when the buffer is empty.
// Backpressure: tready_in low holds tdata/tlast; input side never stalls, overflow drops packets.
module pkt_rx_sf #(
   parameter int          G_MEM_SIZE    = 512,
   parameter logic [15:0] G_PACKET_TYPE = 16'h1234,
   parameter int          G_SIZE_MIN    = 8,
   parameter int          G_SIZE_MAX    = 255,
   parameter int          G_CNT_WIDTH   = 16
) (
   input  logic                   clk_in,
   input  logic                   rst_n_in,
   input  logic [7:0]             rxd_in,
   input  logic                   rxdv_in,
   input  logic                   rxer_in,
   output logic [7:0]             tdata_out,
   output logic                   tvalid_out,
   output logic                   tlast_out,
   input  logic                   tready_in,
   output logic [G_CNT_WIDTH-1:0] stat_packet_vld_cnt,
   output logic [G_CNT_WIDTH-1:0] stat_packet_err_cnt,
   output logic [G_CNT_WIDTH-1:0] stat_packet_drop_cnt
);
   import pkt_rx_pkg::*;

   localparam int AW = $clog2(G_MEM_SIZE);

   state_t      r_state, w_state_nxt;
   logic [7:0]  r_idx, w_idx_nxt;
   logic [7:0]  r_fcs, w_fcs_nxt;
   logic [7:0]  r_size, w_size_nxt;
   logic [7:0]  r_type_hi, w_type_hi_nxt;
   logic        r_nowr, w_nowr_nxt;     // packet does not fit: parse only
   logic        w_wr_en, w_last, w_commit, w_err, w_drop;

   logic [G_CNT_WIDTH-1:0] r_vld_cnt, r_err_cnt, r_drop_cnt;

   logic        r_tvalid, r_tlast, r_skid_vld;
   logic [7:0]  r_tdata;
   logic [8:0]  r_skid_dat;
   logic        w_pop, w_fetch_en, w_rd_vld;
   logic [8:0]  w_rd_dat;
   logic [2:0]  w_fill;
   logic [AW:0] w_free, w_cmt_cnt;

   pkt_rx_buffer #(
      .G_MEM_SIZE (G_MEM_SIZE)
   ) u_buffer (
      .clk_in     (clk_in),
      .rst_n_in   (rst_n_in),
      .i_wr_en    (w_wr_en),
      .i_wr_dat   ({w_last, rxd_in}),
      .i_commit   (w_commit),
      .i_rollback (w_err),
      .i_fetch_en (w_fetch_en),
      .i_pop      (w_pop),
      .o_rd_vld   (w_rd_vld),
      .o_rd_dat   (w_rd_dat),
      .o_free     (w_free),
      .o_cmt_cnt  (w_cmt_cnt)
   );

   // Parser state register.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Parser field registers: byte index, running FCS, size, type high byte, no-write flag.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_idx     <= '0;
         r_fcs     <= '0;
         r_size    <= '0;
         r_type_hi <= '0;
         r_nowr    <= 1'b0;
      end else begin
         r_idx     <= w_idx_nxt;
         r_fcs     <= w_fcs_nxt;
         r_size    <= w_size_nxt;
         r_type_hi <= w_type_hi_nxt;
         r_nowr    <= w_nowr_nxt;
      end
   end

   // Next-state and per-byte strobes; any error rolls the buffer back to the last commit.
   always_comb begin
      w_state_nxt   = r_state;
      w_idx_nxt     = r_idx;
      w_fcs_nxt     = r_fcs;
      w_size_nxt    = r_size;
      w_type_hi_nxt = r_type_hi;
      w_nowr_nxt    = r_nowr;
      w_wr_en       = 1'b0;
      w_last        = 1'b0;
      w_commit      = 1'b0;
      w_err         = 1'b0;
      w_drop        = 1'b0;
      case (r_state)
         IDLE: begin
            if (rxdv_in) begin
               if (rxer_in) begin
                  w_err       = 1'b1;
                  w_state_nxt = PCK_WAIT;
               end else if (rxd_in == sfd_byte(2'd0)) begin
                  w_state_nxt = PCK_SFD;
                  w_idx_nxt   = 8'd1;
               end else begin
                  w_state_nxt = PCK_WAIT;
               end
            end
         end
         PCK_WAIT: begin
            if (!rxdv_in) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            if (!rxdv_in) begin
               // Frame cut short; the line is already idle so a new frame may start next cycle.
               w_err       = 1'b1;
               w_state_nxt = IDLE;
            end else if (rxer_in) begin
               w_err       = 1'b1;
               w_state_nxt = PCK_WAIT;
            end else begin
               case (r_state)
                  PCK_SFD: begin
                     if (rxd_in != sfd_byte(r_idx[1:0])) begin
                        w_state_nxt = PCK_WAIT;   // noise, not a counted error
                     end else if (r_idx == 8'd3) begin
                        w_state_nxt = PCK_TYPE;
                        w_idx_nxt   = 8'd0;
                     end else begin
                        w_idx_nxt = r_idx + 8'd1;
                     end
                  end
                  PCK_TYPE: begin
                     if (r_idx == 8'd0) begin
                        w_type_hi_nxt = rxd_in;
                        w_idx_nxt     = 8'd1;
                     end else if ({r_type_hi, rxd_in} != G_PACKET_TYPE) begin
                        w_err       = 1'b1;
                        w_state_nxt = PCK_WAIT;
                     end else begin
                        w_state_nxt = PCK_SIZE;
                     end
                  end
                  PCK_SIZE: begin
                     if (int'(rxd_in) < G_SIZE_MIN || int'(rxd_in) > G_SIZE_MAX) begin
                        w_err       = 1'b1;
                        w_state_nxt = PCK_WAIT;
                     end else begin
                        w_size_nxt  = rxd_in;
                        w_fcs_nxt   = rxd_in;
                        w_idx_nxt   = 8'd0;
                        w_nowr_nxt  = int'(w_free) < int'(rxd_in);
                        w_state_nxt = (rxd_in == 8'd0) ? PCK_FCS : PCK_PAYLOAD;
                     end
                  end
                  PCK_PAYLOAD: begin
                     w_wr_en   = !r_nowr;
                     w_last    = (r_idx == r_size - 8'd1);
                     w_fcs_nxt = fcs_acc(r_fcs, rxd_in);
                     w_idx_nxt = r_idx + 8'd1;
                     if (w_last) begin
                        w_state_nxt = PCK_FCS;
                     end
                  end
                  PCK_FCS: begin
                     if (rxd_in == r_fcs) begin
                        w_drop   = r_nowr;
                        w_commit = !r_nowr;
                     end else begin
                        w_err = 1'b1;
                     end
                     w_state_nxt = PCK_WAIT;
                  end
                  default: begin
                     w_state_nxt = IDLE;
                  end
               endcase
            end
         end
      endcase
   end

   // Saturating statistics counters, updated on the edge that samples the deciding byte.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_vld_cnt  <= '0;
         r_err_cnt  <= '0;
         r_drop_cnt <= '0;
      end else begin
         if (w_commit && r_vld_cnt != '1) begin
            r_vld_cnt <= r_vld_cnt + 1'b1;
         end
         if (w_err && r_err_cnt != '1) begin
            r_err_cnt <= r_err_cnt + 1'b1;
         end
         if (w_drop && r_drop_cnt != '1) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
         end
      end
   end

   // Fetch only when the output register, skid slot and in-flight read leave room for one more.
   assign w_pop      = r_tvalid & tready_in;
   assign w_fill     = {2'b00, r_tvalid} + {2'b00, r_skid_vld} + {2'b00, w_rd_vld};
   assign w_fetch_en = (w_cmt_cnt != '0) && (w_fill <= ({2'b00, w_pop} + 3'd1));

   // Output register plus one-entry skid that catches the read already in flight on a stall.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_tvalid   <= 1'b0;
         r_tdata    <= '0;
         r_tlast    <= 1'b0;
         r_skid_vld <= 1'b0;
         r_skid_dat <= '0;
      end else if (!r_tvalid || w_pop) begin
         if (r_skid_vld) begin
            r_tvalid             <= 1'b1;
            {r_tlast, r_tdata}   <= r_skid_dat;
            r_skid_vld           <= w_rd_vld;
            r_skid_dat           <= w_rd_dat;
         end else if (w_rd_vld) begin
            r_tvalid             <= 1'b1;
            {r_tlast, r_tdata}   <= w_rd_dat;
         end else begin
            r_tvalid <= 1'b0;
         end
      end else if (w_rd_vld) begin
         r_skid_vld <= 1'b1;
         r_skid_dat <= w_rd_dat;
      end
   end

   assign tdata_out            = r_tdata;
   assign tvalid_out           = r_tvalid;
   assign tlast_out            = r_tlast;
   assign stat_packet_vld_cnt  = r_vld_cnt;
   assign stat_packet_err_cnt  = r_err_cnt;
   assign stat_packet_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_pkt_rx_sf.sv
// Self-checking bench for pkt_rx_sf: scoreboard of expected output bytes plus counter checks.
// Latency: checks the 2-cycle FCS-to-tvalid delay and 1 byte/cycle drain.
// Backpressure: exercises tready_in stalls, overflow drops and wrap-around.
module tb_pkt_rx_sf;

   logic        clk, rst_n;
   logic [7:0]  rxd;
   logic        rxdv, rxer;
   logic [7:0]  tdata;
   logic        tvalid, tlast, tready;
   logic [15:0] cnt_vld, cnt_err, cnt_drop;

   int          n_vec = 0;
   int          n_err = 0;
   logic [8:0]  sb[$];      // expected {tlast, tdata}
   logic [7:0]  fr[$];      // frame being driven
   logic [8:0]  mon_exp;

   pkt_rx_sf #(
      .G_MEM_SIZE    (64),
      .G_PACKET_TYPE (16'h1234),
      .G_SIZE_MIN    (8),
      .G_SIZE_MAX    (63),
      .G_CNT_WIDTH   (16)
   ) u_dut (
      .clk_in               (clk),
      .rst_n_in             (rst_n),
      .rxd_in               (rxd),
      .rxdv_in              (rxdv),
      .rxer_in              (rxer),
      .tdata_out            (tdata),
      .tvalid_out           (tvalid),
      .tlast_out            (tlast),
      .tready_in            (tready),
      .stat_packet_vld_cnt  (cnt_vld),
      .stat_packet_err_cnt  (cnt_err),
      .stat_packet_drop_cnt (cnt_drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Handshakes complete on the next rising edge; sample on the falling edge.
   always @(negedge clk) begin
      if (rst_n && tvalid && tready) begin
         chk("out_pending", (sb.size() != 0) ? 32'd1 : 32'd0, 32'd1);
         if (sb.size() != 0) begin
            mon_exp = sb.pop_front();
            chk("out_byte", 32'({tlast, tdata}), 32'(mon_exp));
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic build(input logic [15:0] typ, input int n, input logic [7:0] base,
                        input logic [7:0] fcs_xor, input bit push);
      logic [7:0] s;
      logic [7:0] b;
      fr.delete();
      fr.push_back(8'h55); fr.push_back(8'h55); fr.push_back(8'h55); fr.push_back(8'h7F);
      fr.push_back(typ[15:8]); fr.push_back(typ[7:0]); fr.push_back(8'(n));
      s = 8'(n);
      for (int i = 0; i < n; i++) begin
         b = base + 8'(i);
         fr.push_back(b);
         s = s + b;
         if (push) sb.push_back({(i == n - 1), b});
      end
      fr.push_back(s ^ fcs_xor);
   endtask

   task automatic drive(input int nbytes, input int er_at);
      for (int i = 0; i < nbytes; i++) begin
         @(posedge clk); #1;
         rxdv = 1'b1; rxd = fr[i]; rxer = (i == er_at);
      end
      @(posedge clk); #1;
      rxdv = 1'b0; rxer = 1'b0; rxd = 8'h00;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int k = 0;
      while ((sb.size() != 0 || tvalid) && k < 400) begin
         @(posedge clk); #1;
         k++;
      end
      idle(4);
      chk("drain_left", 32'(sb.size()), 0);
   endtask

   task automatic chk_cnt(input string tag, input int v, input int e, input int d);
      chk({tag, "_vld"},  32'(cnt_vld),  v);
      chk({tag, "_err"},  32'(cnt_err),  e);
      chk({tag, "_drop"}, 32'(cnt_drop), d);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_tvalid"}, 32'(tvalid), 0);
      chk({tag, "_tlast"},  32'(tlast),  0);
      chk({tag, "_tdata"},  32'(tdata),  0);
      chk_cnt(tag, 0, 0, 0);
   endtask

   initial begin
      int k;
      rst_n = 1'b0; rxd = 8'h00; rxdv = 1'b0; rxer = 1'b0; tready = 1'b1;
      idle(3);
      chk_reset("rst");
      rst_n = 1'b1;
      idle(2);

      // Good packet, latency and content.
      build(16'h1234, 8, 8'h01, 8'h00, 1'b1);
      chk("fcs_model", 32'(fr[15]), 32'h2C);
      drive(fr.size(), -1);
      chk("lat_e0", 32'(tvalid), 0);
      @(posedge clk); #1; chk("lat_e1", 32'(tvalid), 0);
      @(posedge clk); #1; chk("lat_e2", 32'(tvalid), 1);
      chk("lat_dat", 32'(tdata), 32'h01);
      drain();
      chk_cnt("good", 1, 0, 0);

      // Bad FCS, then a good packet must come through intact.
      build(16'h1234, 8, 8'h01, 8'h01, 1'b0);
      drive(fr.size(), -1);
      idle(4);
      chk("badfcs_novld", 32'(tvalid), 0);
      chk_cnt("badfcs", 1, 1, 0);
      build(16'h1234, 8, 8'h10, 8'h00, 1'b1);
      drive(fr.size(), -1);
      drain();
      chk_cnt("after_bad", 2, 1, 0);

      // rxer on payload byte 3, wrong type, short and long size.
      build(16'h1234, 8, 8'h30, 8'h00, 1'b0); drive(fr.size(), 10);
      build(16'h1235, 8, 8'h30, 8'h00, 1'b0); drive(fr.size(), -1);
      build(16'h1234, 7, 8'h30, 8'h00, 1'b0); drive(fr.size(), -1);
      build(16'h1234, 64, 8'h30, 8'h00, 1'b0); drive(fr.size(), -1);
      idle(4);
      chk("errs_novld", 32'(tvalid), 0);
      chk_cnt("errs", 2, 5, 0);
      // Frame cut mid-payload, next frame starts one cycle after rxdv falls.
      build(16'h1234, 9, 8'h50, 8'h00, 1'b0); drive(12, -1);
      build(16'h1234, 9, 8'h60, 8'h00, 1'b1); drive(fr.size(), -1);
      // Broken SFD is noise; trailing bytes after a good FCS are ignored.
      build(16'h1234, 8, 8'h70, 8'h00, 1'b0); fr[2] = 8'hAA; drive(fr.size(), -1);
      build(16'h1234, 10, 8'h80, 8'h00, 1'b1);
      fr.push_back(8'hEE); fr.push_back(8'h11);
      drive(fr.size(), -1);
      drain();
      chk_cnt("mixed", 4, 6, 0);

      // Three back-to-back packets stalled, then released at full rate.
      tready = 1'b0;
      build(16'h1234, 8, 8'h20, 8'h00, 1'b1); drive(fr.size(), -1);
      build(16'h1234, 8, 8'h40, 8'h00, 1'b1); drive(fr.size(), -1);
      build(16'h1234, 8, 8'h60, 8'h00, 1'b1); drive(fr.size(), -1);
      idle(4);
      chk("stall_vld", 32'(tvalid), 1);
      chk("stall_dat", 32'(tdata), 32'(sb[0][7:0]));
      idle(3);
      chk("stall_hold", 32'({tlast, tdata}), 32'(sb[0]));
      tready = 1'b1;
      k = 0;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         if (tvalid) k++;
      end
      chk("thruput", 32'(k), 24);
      drain();
      chk_cnt("b2b", 7, 6, 0);

      // Reset mid-payload while output is stalled with data pending.
      tready = 1'b0;
      build(16'h1234, 8, 8'hA0, 8'h00, 1'b1); drive(fr.size(), -1);
      build(16'h1234, 20, 8'hB0, 8'h00, 1'b0);
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         rxdv = 1'b1; rxd = fr[i];
      end
      chk("pre_rst_vld", 32'(tvalid), 1);
      rst_n = 1'b0;
      sb.delete();
      rxdv = 1'b0; rxd = 8'h00;
      idle(1);
      chk_reset("midrst");
      rst_n = 1'b1; tready = 1'b1;
      idle(2);
      build(16'h1234, 8, 8'hC0, 8'h00, 1'b1); drive(fr.size(), -1);
      drain();
      chk_cnt("post_rst", 1, 0, 0);

      // Overflow with a 64-byte buffer, then a packet that wraps the buffer.
      tready = 1'b0;
      build(16'h1234, 40, 8'h01, 8'h00, 1'b1); drive(fr.size(), -1);
      build(16'h1234, 40, 8'h81, 8'h00, 1'b0); drive(fr.size(), -1);
      idle(3);
      chk_cnt("ovf", 2, 0, 1);
      tready = 1'b1;
      drain();
      build(16'h1234, 40, 8'hC1, 8'h00, 1'b1); drive(fr.size(), -1);
      drain();
      chk_cnt("wrap", 3, 0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pkt_rx_sf.md
# pkt_rx_sf

Parametrised store-and-forward packet receiver, the successor to the single-packet receive path. It parses framed byte packets from the MII-style `rxd`/`rxdv`/`rxer` input and checks SFD, type, size and FCS. Packets are written into a circular buffer with commit/rollback, so several good packets can queue while a bad one is discarded in place. Committed packets are replayed on an AXI-Stream style byte output with `tlast`, and saturating statistics counters are kept.

## Interface
Parameters:
- `G_MEM_SIZE`, 512: buffer depth in bytes. Must be a power of 2 and at least `G_SIZE_MAX`+1.
- `G_PACKET_TYPE`, 16'h1234: accepted type field.
- `G_SIZE_MIN`, 8: minimum payload length.
- `G_SIZE_MAX`, 255: maximum payload length, at most 255.
- `G_CNT_WIDTH`, 16: width of the statistics counters.

Ports:
- `clk_in` in 1: single clock; all logic on its rising edge.
- `rst_n_in` in 1: reset, asynchronous, active-low.
- `rxd_in` in 8: receive byte.
- `rxdv_in` in 1: receive data valid.
- `rxer_in` in 1: receive error.
- `tdata_out` out 8: output byte.
- `tvalid_out` out 1: output valid.
- `tlast_out` out 1: last payload byte of the packet.
- `tready_in` in 1: downstream ready.
- `stat_packet_vld_cnt` out `G_CNT_WIDTH`: packets committed.
- `stat_packet_err_cnt` out `G_CNT_WIDTH`: packets failing a check.
- `stat_packet_drop_cnt` out `G_CNT_WIDTH`: good packets lost to buffer overflow.

## Operation
- Frame format, one byte per cycle while `rxdv_in`=1:
  - SFD: 55 55 55 7F.
  - Type: high byte, then low byte.
  - Size N.
  - N payload bytes.
  - FCS: the 8-bit sum mod 256 of the size byte and all payload bytes.
- Only the payload bytes are stored.
- FSM states: IDLE, PCK_SFD, PCK_TYPE, PCK_SIZE, PCK_PAYLOAD, PCK_FCS, PCK_WAIT.
- IDLE → PCK_SFD on the first `rxdv_in`=1 byte. That byte is SFD byte 0.
- SFD byte mismatch → PCK_WAIT. This is not counted; it is line noise.
- Type ≠ `G_PACKET_TYPE`, N < `G_SIZE_MIN`, N > `G_SIZE_MAX`, or FCS mismatch → error.
- `rxer_in`=1 on any byte of a frame, or `rxdv_in` falling before the FCS byte → error.
- Error handling: increment the err counter, roll back the write pointer to the committed pointer, go to PCK_WAIT. If `rxdv_in` has already fallen, go to IDLE instead.
- FCS match → commit: the committed pointer takes the write pointer, the vld counter increments, go to PCK_WAIT.
- PCK_WAIT → IDLE when `rxdv_in`=0. Trailing bytes after the FCS are ignored, and the packet stays valid.
- Each buffer entry is 9 bits: the data byte plus a last flag, which is set on payload byte N-1.
- Overflow check at PCK_SIZE: if free space (`G_MEM_SIZE` − occupancy) < N, the packet is parsed but not written.
  - If that packet later passes all checks, the drop counter increments and the vld counter does not.
  - If it fails a check, only the err counter increments.
- Counters saturate at all-ones.
- Output side: reads proceed only while committed data is present.
  - The read pointer advances on each `tvalid_out` && `tready_in` handshake.
  - `tdata_out`/`tvalid_out`/`tlast_out` are registered.
  - `tdata_out` and `tlast_out` hold stable while `tvalid_out`=1 && `tready_in`=0.
- Pointers are `$clog2(G_MEM_SIZE)`+1 bits wide; the extra bit is the wrap bit. Full and empty are distinguished by that MSB.

## Timing
- Reset values: FSM in IDLE; all pointers 0; `tvalid_out`=0, `tlast_out`=0, `tdata_out`=0; all counters 0.
- Reset mid-packet discards the partial packet and all uncommitted and unread data.
- Commit occurs on the clock edge that samples the FCS byte. Counters update on that same edge.
- First `tvalid_out`=1 comes 2 cycles after the FCS byte edge, if the buffer was empty.
- Output sustains 1 byte/cycle with `tready_in` held at 1, including across packet boundaries.
- Simultaneous commit and read: the read uses the old committed pointer. There is no combinational path from commit to `tvalid_out`.
- Rollback never touches committed or unread bytes.
- A rising `rxdv_in` in the cycle after a falling `rxdv_in` is accepted as a new frame.

## Structure
- Package `pkt_rx_pkg`: `state_t` enum, `C_SFD` = 32'h5555557F, and the FCS accumulate function.
- Sub-module `pkt_rx_buffer`:
  - dual-port circular 9-bit RAM;
  - write, commit and rollback pointers;
  - read pointer;
  - free-space and committed-count outputs;
  - registered read port.
- Top level: FSM, checks, counters, and output skid register.

## Test plan
- Good packet, type 1234, N=8, payload 01..08, FCS 0x2C → 8 output bytes 01..08 with `tlast_out` on 08, vld=1, err=0.
- Same packet with FCS 0x2D → no output, err=1. The next good packet is output intact.
- `rxer_in` pulsed on payload byte 3; separately, type 0x1235; separately, N=7 → err=3, no output, write pointer unchanged.
- Three back-to-back good packets with `tready_in`=0, then release → all three output in order, with `tlast_out` at each end. 1 byte/cycle throughput.
- `G_MEM_SIZE`=64, `tready_in`=0, packets of N=40 sent twice → first packet committed, second counted as drop. After draining, a third packet is accepted across the wrap point.
- `rst_n_in` asserted mid-payload and mid-output → all outputs and counters return to 0. The next packet is received normally.
